set_assoc_cache_ctrl: RTL and testbench

//   Parametrised N-way set-associative, write-back, write-allocate cache with integrated controller FSM.

---
 rtl/set_assoc_cache_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_set_assoc_cache_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_cache_ctrl.sv
// N-way set-associative write-back/write-allocate cache with LRU replacement.
// One CPU word port on one side, one line-wide memory port on the other.
module set_assoc_cache_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int WORD_W     = 32,
    parameter int LINE_BYTES = 64,
    parameter int NUM_SETS   = 128,
    parameter int NUM_WAYS   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [WORD_W-1:0]         req_wdata,
    output logic                      rsp_valid,
    output logic [WORD_W-1:0]         rsp_rdata,
    output logic                      rsp_hit,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [LINE_BYTES*8-1:0]   mem_wdata,
    input  logic [LINE_BYTES*8-1:0]   mem_rdata,
    input  logic                      mem_ack
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int AGE_W  = $clog2(NUM_WAYS);
    localparam int BSEL_W = $clog2(WORD_W / 8);
    localparam int WIDX_W = OFF_W - BSEL_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;

    state_t state, next_state;

    logic [TAG_W-1:0]  tag_mem   [NUM_SETS][NUM_WAYS];
    logic [LINE_W-1:0] data_mem  [NUM_SETS][NUM_WAYS];
    logic              valid_mem [NUM_SETS][NUM_WAYS];
    logic              dirty_mem [NUM_SETS][NUM_WAYS];
    logic [AGE_W-1:0]  age_mem   [NUM_SETS][NUM_WAYS];

    logic              r_we;
    logic [TAG_W-1:0]  r_tag;
    logic [IDX_W-1:0]  r_idx;
    logic [WIDX_W-1:0] r_widx;
    logic [WORD_W-1:0] r_wdata;
    logic              hit_q;
    logic [AGE_W-1:0]  way_q;
    logic [WORD_W-1:0] hold_rdata;
    logic              hold_hit;

    logic              hit;
    logic              found_inv;
    logic [AGE_W-1:0]  hit_way;
    logic [AGE_W-1:0]  victim;
    logic [LINE_W-1:0] cur_line;
    logic [LINE_W-1:0] merged_line;
    logic [WORD_W-1:0] resp_word;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^req_addr[BSEL_W-1:0];

    // Tag compare and victim choice: first invalid way, otherwise the oldest.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        found_inv = 1'b0;
        victim    = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_mem[r_idx][w] && tag_mem[r_idx][w] == r_tag) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!found_inv && !valid_mem[r_idx][w]) begin
                found_inv = 1'b1;
                victim    = AGE_W'(w);
            end
        end
        if (!found_inv) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (age_mem[r_idx][w] == AGE_W'(NUM_WAYS - 1)) victim = AGE_W'(w);
            end
        end
    end

    always_comb begin
        cur_line    = data_mem[r_idx][way_q];
        merged_line = cur_line;
        merged_line[r_widx*WORD_W +: WORD_W] = r_wdata;
        resp_word   = r_we ? r_wdata : cur_line[r_widx*WORD_W +: WORD_W];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_rdata  = hold_rdata;
        rsp_hit    = hold_hit;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) next_state = LOOKUP;
            end
            LOOKUP: begin
                if (hit)
                    next_state = RESPOND;
                else if (valid_mem[r_idx][victim] && dirty_mem[r_idx][victim])
                    next_state = WRITEBACK;
                else
                    next_state = REFILL;
            end
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_mem[r_idx][way_q], r_idx, {OFF_W{1'b0}}};
                mem_wdata = cur_line;
                if (mem_ack) next_state = REFILL;
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {r_tag, r_idx, {OFF_W{1'b0}}};
                if (mem_ack) next_state = RESPOND;
            end
            RESPOND: begin
                rsp_valid  = 1'b1;
                rsp_rdata  = resp_word;
                rsp_hit    = hit_q;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Request capture, line metadata and LRU ages; ages stay a permutation per set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we       <= 1'b0;
            r_tag      <= '0;
            r_idx      <= '0;
            r_widx     <= '0;
            r_wdata    <= '0;
            hit_q      <= 1'b0;
            way_q      <= '0;
            hold_rdata <= '0;
            hold_hit   <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid_mem[s][w] <= 1'b0;
                    dirty_mem[s][w] <= 1'b0;
                    age_mem[s][w]   <= AGE_W'(w);
                end
            end
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    r_we    <= req_we;
                    r_tag   <= req_addr[ADDR_W-1 -: TAG_W];
                    r_idx   <= req_addr[OFF_W +: IDX_W];
                    r_widx  <= req_addr[BSEL_W +: WIDX_W];
                    r_wdata <= req_wdata;
                end
                LOOKUP: begin
                    hit_q <= hit;
                    way_q <= hit ? hit_way : victim;
                end
                REFILL: if (mem_ack) begin
                    valid_mem[r_idx][way_q] <= 1'b1;
                    dirty_mem[r_idx][way_q] <= 1'b0;
                end
                RESPOND: begin
                    hold_rdata <= resp_word;
                    hold_hit   <= hit_q;
                    if (r_we) dirty_mem[r_idx][way_q] <= 1'b1;
                    for (int w = 0; w < NUM_WAYS; w++) begin
                        if (AGE_W'(w) == way_q)
                            age_mem[r_idx][w] <= '0;
                        else if (age_mem[r_idx][w] < age_mem[r_idx][way_q])
                            age_mem[r_idx][w] <= age_mem[r_idx][w] + AGE_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == REFILL && mem_ack) begin
            data_mem[r_idx][way_q] <= mem_rdata;
            tag_mem[r_idx][way_q]  <= r_tag;
        end else if (state == RESPOND && r_we) begin
            data_mem[r_idx][way_q] <= merged_line;
        end
    end
endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Scoreboard bench for set_assoc_cache_ctrl: directed CPU requests, a memory
// model that checks each memory transaction, and a response monitor.
module tb_set_assoc_cache_ctrl;
    localparam int LINE_W = 512;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [31:0]       req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_hit;
    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata = '0;
    logic              mem_ack = 1'b0;

    set_assoc_cache_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_hit(rsp_hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        hit;
        logic [31:0] acc;
    } rsp_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  widx;
        logic [31:0] wval;
    } mem_t;

    rsp_t sb[$];
    mem_t mexp[$];
    logic [LINE_W-1:0] mem_store [logic [31:0]];

    int cyc = 0;
    int ack_cyc = 0;
    int rsp_count = 0;
    int checks = 0;
    int fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Untouched memory: each word holds its own byte address, except word0 of line 0x1040.
    function automatic logic [LINE_W-1:0] line_of(input logic [31:0] a);
        logic [LINE_W-1:0] l;
        if (mem_store.exists(a)) return mem_store[a];
        for (int w = 0; w < 16; w++) l[w*32 +: 32] = a + 32'(w * 4);
        if (a == 32'h0000_1040) l[31:0] = 32'hA5A5_0001;
        return l;
    endfunction

    // Memory model: checks each transaction against expectations, acks after 3 cycles.
    initial begin
        mem_t e;
        logic aborted;
        forever begin
            @(negedge clk);
            if (rst && mem_req) begin
                if (mexp.size() == 0) begin
                    checkOutput("mem_unexpected", 1, 0);
                    e = '{we: mem_we, addr: mem_addr, widx: 0, wval: 0};
                end else begin
                    e = mexp.pop_front();
                    checkOutput("mem_we", {63'd0, mem_we}, {63'd0, e.we});
                    checkOutput("mem_addr", {32'd0, mem_addr}, {32'd0, e.addr});
                    if (e.we)
                        checkOutput("wb_word", {32'd0, mem_wdata[e.widx*32 +: 32]}, {32'd0, e.wval});
                end
                if (mem_we) mem_store[mem_addr] = mem_wdata;
                aborted = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    if (!mem_req) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted) begin
                    checkOutput("mem_addr_stable", {32'd0, mem_addr}, {32'd0, e.addr});
                    mem_rdata = line_of(mem_addr);
                    mem_ack   = 1'b1;
                    ack_cyc   = cyc;
                    @(negedge clk);
                    mem_ack   = 1'b0;
                end
            end
        end
    end

    // Response monitor: hits respond two cycles after accept, misses one cycle after the last ack.
    always @(negedge clk) begin
        rsp_t e;
        if (rst && rsp_valid) begin
            rsp_count++;
            if (sb.size() == 0) begin
                checkOutput("rsp_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
                checkOutput("rsp_hit", {63'd0, rsp_hit}, {63'd0, e.hit});
                if (e.hit) checkOutput("lat_hit", 64'(cyc), 64'(e.acc + 2));
                else       checkOutput("lat_miss", 64'(cyc), 64'(ack_cyc + 1));
            end
        end
    end

    task automatic expectMem(input logic we, input logic [31:0] addr, input logic [3:0] widx, input logic [31:0] wval);
        mexp.push_back('{we: we, addr: addr, widx: widx, wval: wval});
    endtask

    task automatic waitIdle();
        int n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) checkOutput("idle_timeout", 1, 0);
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_hit, input logic track);
        waitIdle();
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        if (track) sb.push_back('{rdata: exp_rdata, hit: exp_hit, acc: 32'(cyc)});
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata, input logic exp_hit);
        int start;
        int n = 0;
        start = rsp_count;
        issue(we, addr, wdata, exp_rdata, exp_hit, 1'b1);
        while (rsp_count == start && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) checkOutput("rsp_timeout", 1, 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        checkOutput("rst_req_ready", {63'd0, req_ready}, 64'd1);
        checkOutput("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        checkOutput("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        checkOutput("rst_rsp_hit", {63'd0, rsp_hit}, 64'd0);
        checkOutput("rst_mem_req", {63'd0, mem_req}, 64'd0);
        checkOutput("rst_mem_we", {63'd0, mem_we}, 64'd0);
        checkOutput("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        checkOutput("rst_mem_wdata", {63'd0, |mem_wdata}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Set 0x41: cold miss, hits, write hit makes way0 dirty.
        expectMem(0, 32'h0000_1040, 0, 0);
        applyStimulus(0, 32'h0000_1040, 0, 32'hA5A5_0001, 0);
        applyStimulus(0, 32'h0000_1040, 0, 32'hA5A5_0001, 1);
        applyStimulus(1, 32'h0000_1044, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
        applyStimulus(0, 32'h0000_1044, 0, 32'hDEAD_BEEF, 1);

        // Fill remaining ways with tags 1..3, then touch tag1: ages [3,0,2,1].
        expectMem(0, 32'h0000_3040, 0, 0);
        applyStimulus(0, 32'h0000_3040, 0, 32'h0000_3040, 0);
        expectMem(0, 32'h0000_5040, 0, 0);
        applyStimulus(0, 32'h0000_5040, 0, 32'h0000_5040, 0);
        expectMem(0, 32'h0000_7040, 0, 0);
        applyStimulus(0, 32'h0000_7040, 0, 32'h0000_7040, 0);
        applyStimulus(0, 32'h0000_3040, 0, 32'h0000_3040, 1);

        // Tag4 evicts dirty tag0 (write-back first), tag5 evicts tag2, tag1 survives.
        expectMem(1, 32'h0000_1040, 4'd1, 32'hDEAD_BEEF);
        expectMem(0, 32'h0000_9040, 0, 0);
        applyStimulus(0, 32'h0000_9040, 0, 32'h0000_9040, 0);
        expectMem(0, 32'h0000_B040, 0, 0);
        applyStimulus(0, 32'h0000_B040, 0, 32'h0000_B040, 0);
        applyStimulus(0, 32'h0000_3040, 0, 32'h0000_3040, 1);
        expectMem(0, 32'h0000_5040, 0, 0);
        applyStimulus(0, 32'h0000_5040, 0, 32'h0000_5040, 0);

        // Written-back line comes home intact (clean victim tag4, no write-back).
        expectMem(0, 32'h0000_1040, 0, 0);
        applyStimulus(0, 32'h0000_1040, 0, 32'hA5A5_0001, 0);
        applyStimulus(0, 32'h0000_1044, 0, 32'hDEAD_BEEF, 1);
        applyStimulus(0, 32'h0000_1048, 0, 32'h0000_1048, 1);

        // Write miss allocates and merges at word 2.
        expectMem(0, 32'h0000_2080, 0, 0);
        applyStimulus(1, 32'h0000_2088, 32'h1234_5678, 32'h1234_5678, 0);
        applyStimulus(0, 32'h0000_2084, 0, 32'h0000_2084, 1);
        applyStimulus(0, 32'h0000_2088, 0, 32'h1234_5678, 1);

        // Reset in the middle of a refill.
        expectMem(0, 32'h0000_4000, 0, 0);
        issue(0, 32'h0000_4000, 0, 0, 0, 1'b0);
        n = 0;
        while (!mem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("refill_started", {63'd0, mem_req}, 64'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("abort_mem_req", {63'd0, mem_req}, 64'd0);
        checkOutput("abort_req_ready", {63'd0, req_ready}, 64'd1);
        checkOutput("abort_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        expectMem(0, 32'h0000_2080, 0, 0);
        applyStimulus(0, 32'h0000_2088, 0, 32'h0000_2088, 0);

        waitIdle();
        repeat (5) @(negedge clk);
        checkOutput("sb_drained", 64'(sb.size()), 64'd0);
        checkOutput("mem_drained", 64'(mexp.size()), 64'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got timeout expected finish");
        $fatal(1, "[TB] timeout");
    end
endmodule
